imem_dmem_arbiter: RTL and testbench
====================================

Name: imem_dmem_arbiter

Overview:
- Shares one single-port synchronous memory (unified instruction/data RAM) between the core's instruction-fetch port and its load/store port.
- Sits between DATAPATH's fetch and memory stages and the unified memory macro. It replaces the separate instruction_memory/data_memory pair in the unified-memory build.
- Grants at most one access per cycle. Data accesses win, except that a starvation counter forces a fetch grant after MAX_WAIT consecutive denials.
- Read data returns one cycle after grant and is steered back to the requester that issued it.

Parameters:
- AW, 32, address width (byte address).
- DW, 32, data width; must be a multiple of 8.
- MAX_WAIT, 4, consecutive denied fetch cycles before fetch is forced to win; legal range 1..15.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rstn  input  1  asynchronous active-low reset.
- i_if_req  input  1  fetch request; held until granted.
- i_if_addr  input  AW  fetch address.
- o_if_gnt  output  1  fetch accepted this cycle.
- o_if_rvalid  output  1  fetch data valid.
- o_if_rdata  output  DW  fetched instruction.
- i_d_req  input  1  data request; held until granted.
- i_d_wen  input  1  1 = store, 0 = load.
- i_d_addr  input  AW  data address.
- i_d_wdata  input  DW  store data.
- i_d_be  input  DW/8  store byte enables.
- o_d_gnt  output  1  data access accepted this cycle.
- o_d_rvalid  output  1  load data valid.
- o_d_rdata  output  DW  load data.
- o_mem_en  output  1  memory access strobe.
- o_mem_wen  output  1  memory write.
- o_mem_addr  output  AW  memory address.
- o_mem_wdata  output  DW  memory write data.
- o_mem_be  output  DW/8  memory byte enables.
- i_mem_rdata  input  DW  memory read data; valid the cycle after a read strobe.

Behaviour:
- Grant logic (combinational from requests and state):
  - force_if = (starve_cnt == MAX_WAIT).
  - o_d_gnt = i_d_req & ~(force_if & i_if_req).
  - o_if_gnt = i_if_req & ~o_d_gnt.
  - Never both high.
- Memory port (combinational mux of the granted requester):
  - o_mem_en = o_if_gnt | o_d_gnt.
  - Data granted: o_mem_addr/wdata/be/wen come from the d_ inputs.
  - Fetch granted: o_mem_addr = i_if_addr, o_mem_wen = 0, o_mem_be = all ones, o_mem_wdata = 0.
  - Idle: all memory outputs 0.
- Response FSM, registered, states RSP_NONE, RSP_IF, RSP_D:
  - Next state is RSP_IF on a fetch grant, RSP_D on a data-load grant, else RSP_NONE. A store grant leads to RSP_NONE.
  - o_if_rvalid = (state == RSP_IF); o_d_rvalid = (state == RSP_D).
  - o_if_rdata and o_d_rdata are i_mem_rdata when their rvalid is high, else 0.
  - Latency: grant in cycle N gives rvalid in cycle N+1.
  - Fully pipelined: a new grant may be issued in the same cycle a response is delivered, for back-to-back throughput of 1 access/cycle.
- Starvation counter starve_cnt, 4 bits:
  - Increments, saturating at MAX_WAIT, on a cycle where i_if_req=1 and o_if_gnt=0.
  - Clears on a fetch grant or when i_if_req=0.
  - Fetch therefore waits at most MAX_WAIT cycles while data requests every cycle.
- Simultaneous requests with force_if=0: data wins and the counter increments.
- Simultaneous requests with force_if=1: fetch wins and the counter clears. Data stays pending and wins next cycle.
- Reset, asynchronous, effective immediately regardless of i_clk:
  - State goes to RSP_NONE and starve_cnt to 0.
  - All rvalid outputs go to 0. With requests low, all grant and memory outputs are 0.
  - Reset mid-access discards the pending response; no rvalid follows reset deassertion.
- Requester contract: address, data and wen are stable while req is high and not granted. The arbiter does not latch requests.

Test Plan:
- Reset with no requests → all outputs 0. Assert i_rstn=0 mid-cycle after a fetch grant → o_if_rvalid stays 0 the next cycle.
- Fetch only: i_if_addr=0x10 for one cycle, memory returns 0x00500093 → o_if_gnt=1 in cycle N; o_if_rvalid=1 with o_if_rdata=0x00500093 in N+1.
- Store: i_d_wen=1, addr=0x200, wdata=0xDEADBEEF, be=4'b0011 → o_mem_wen=1 with those values; no o_d_rvalid follows. A later load of 0x200 returns the memory's 0x0000BEEF in N+1 on o_d_rdata.
- Contention, MAX_WAIT=4, both requests held high → data granted in cycles 0–3, fetch in cycle 4, data in cycle 5. The rvalids alternate correctly one cycle later.
- Back-to-back alternating load/fetch, each held one cycle → 1 grant/cycle. Each rvalid goes to the correct port with the correct i_mem_rdata; the other port's rdata is 0.
- Data request drops in the cycle the counter would saturate → fetch granted normally and starve_cnt clears to 0.

Source files
------------

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter
// Shares one single-port synchronous RAM between the instruction-fetch port
// and the load/store port. Data accesses normally win; a starvation counter
// forces a fetch grant once fetch has been denied MAX_WAIT cycles in a row.
// Read data comes back one cycle after the grant and is steered to the
// requester that was granted, so one access per cycle is sustained.
module imem_dmem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  // instruction-fetch port
  input  logic            i_if_req,
  input  logic [AW-1:0]   i_if_addr,
  output logic            o_if_gnt,
  output logic            o_if_rvalid,
  output logic [DW-1:0]   o_if_rdata,
  // load/store port
  input  logic            i_d_req,
  input  logic            i_d_wen,
  input  logic [AW-1:0]   i_d_addr,
  input  logic [DW-1:0]   i_d_wdata,
  input  logic [DW/8-1:0] i_d_be,
  output logic            o_d_gnt,
  output logic            o_d_rvalid,
  output logic [DW-1:0]   o_d_rdata,
  // unified memory macro
  output logic            o_mem_en,
  output logic            o_mem_wen,
  output logic [AW-1:0]   o_mem_addr,
  output logic [DW-1:0]   o_mem_wdata,
  output logic [DW/8-1:0] o_mem_be,
  input  logic [DW-1:0]   i_mem_rdata
);

  localparam int BW = DW / 8;

  // The counter is 4 bits wide, which bounds MAX_WAIT to 1..15.
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  // Which requester owns the read data arriving this cycle.
  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_IF   = 2'd1,
    RSP_D    = 2'd2
  } rsp_state_t;

  rsp_state_t r_state;
  rsp_state_t w_state_next;
  logic [3:0] r_starve_cnt;
  logic [3:0] w_starve_next;
  logic       w_force_if;
  logic       w_d_gnt;
  logic       w_if_gnt;

  // Grant: data wins unless fetch has waited MAX_WAIT cycles and still wants in.
  assign w_force_if = (r_starve_cnt == MAX_WAIT_C);
  assign w_d_gnt    = i_d_req & ~(w_force_if & i_if_req);
  assign w_if_gnt   = i_if_req & ~w_d_gnt;

  assign o_d_gnt    = w_d_gnt;
  assign o_if_gnt   = w_if_gnt;
  assign o_mem_en   = w_if_gnt | w_d_gnt;

  // Memory port mux: drive the granted requester's fields, zeros when idle.
  always_comb begin
    // NOTE: every output gets a default first so no path through the block
    // leaves a signal unassigned, which would otherwise infer a latch.
    o_mem_wen   = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_be    = '0;
    if (w_d_gnt) begin
      o_mem_wen   = i_d_wen;
      o_mem_addr  = i_d_addr;
      o_mem_wdata = i_d_wdata;
      o_mem_be    = i_d_be;
    end else if (w_if_gnt) begin
      o_mem_addr  = i_if_addr;
      o_mem_be    = {BW{1'b1}};
    end
  end

  // Response next state: remember who gets the read data next cycle.
  always_comb begin
    w_state_next = RSP_NONE;
    if (w_if_gnt) begin
      w_state_next = RSP_IF;
    end else if (w_d_gnt && !i_d_wen) begin
      w_state_next = RSP_D;
    end
  end

  // Starvation count: grows (saturating) while fetch waits, clears otherwise.
  always_comb begin
    w_starve_next = 4'd0;
    if (i_if_req && !w_if_gnt) begin
      if (r_starve_cnt == MAX_WAIT_C) begin
        w_starve_next = r_starve_cnt;
      end else begin
        w_starve_next = r_starve_cnt + 4'd1;
      end
    end
  end

  // State register; reset drops any response still in flight.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    if (!i_rstn) begin
      r_state      <= RSP_NONE;
      r_starve_cnt <= 4'd0;
    end else begin
      r_state      <= w_state_next;
      r_starve_cnt <= w_starve_next;
    end
  end

  // Response steering: only the owning port sees read data, the other gets 0.
  assign o_if_rvalid = (r_state == RSP_IF);
  assign o_d_rvalid  = (r_state == RSP_D);
  assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
  assign o_d_rdata   = o_d_rvalid  ? i_mem_rdata : '0;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb_imem_dmem_arbiter
// Directed scenarios followed by randomized traffic, all compared against a
// transaction-level reference model (pending-response record, wait counter
// and a word array for memory contents).
module tb_imem_dmem_arbiter;

  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int BW       = DW / 8;
  localparam int MAX_WAIT = 4;
  localparam int NWORDS   = 64;

  logic            i_clk = 1'b0;
  logic            i_rstn;
  logic            i_if_req;
  logic [AW-1:0]   i_if_addr;
  logic            o_if_gnt;
  logic            o_if_rvalid;
  logic [DW-1:0]   o_if_rdata;
  logic            i_d_req;
  logic            i_d_wen;
  logic [AW-1:0]   i_d_addr;
  logic [DW-1:0]   i_d_wdata;
  logic [BW-1:0]   i_d_be;
  logic            o_d_gnt;
  logic            o_d_rvalid;
  logic [DW-1:0]   o_d_rdata;
  logic            o_mem_en;
  logic            o_mem_wen;
  logic [AW-1:0]   o_mem_addr;
  logic [DW-1:0]   o_mem_wdata;
  logic [BW-1:0]   o_mem_be;
  logic [DW-1:0]   i_mem_rdata;

  imem_dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_if_req    (i_if_req),
    .i_if_addr   (i_if_addr),
    .o_if_gnt    (o_if_gnt),
    .o_if_rvalid (o_if_rvalid),
    .o_if_rdata  (o_if_rdata),
    .i_d_req     (i_d_req),
    .i_d_wen     (i_d_wen),
    .i_d_addr    (i_d_addr),
    .i_d_wdata   (i_d_wdata),
    .i_d_be      (i_d_be),
    .o_d_gnt     (o_d_gnt),
    .o_d_rvalid  (o_d_rvalid),
    .o_d_rdata   (o_d_rdata),
    .o_mem_en    (o_mem_en),
    .o_mem_wen   (o_mem_wen),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_be    (o_mem_be),
    .i_mem_rdata (i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Memory macro seen by the DUT (driven by the DUT's own port outputs).
  logic [DW-1:0] env_mem [NWORDS];
  logic          cap_en, cap_wen;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_wdata;
  logic [BW-1:0] cap_be;

  // Reference model: its own memory, pending response and wait counter.
  logic [DW-1:0] ref_mem [NWORDS];
  int            m_pend;          // 0 none, 1 fetch, 2 data
  logic [DW-1:0] m_pend_data;
  int            m_wait;
  logic          m_ig, m_dg;      // grants expected in the last evaluated cycle

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r = old_w;
    for (int b = 0; b < BW; b++)
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Mid-cycle: compare every DUT output with the model, then advance the model.
  task automatic eval_cycle();
    logic            force_if, dg, ig, e_wen;
    logic [AW-1:0]   e_addr;
    logic [DW-1:0]   e_wdata;
    logic [BW-1:0]   e_be;
    int              idx;
    @(negedge i_clk);
    force_if = (m_wait == MAX_WAIT);
    dg = i_d_req && !(force_if && i_if_req);
    ig = i_if_req && !dg;
    e_wen = 1'b0; e_addr = '0; e_wdata = '0; e_be = '0;
    if (dg) begin
      e_wen = i_d_wen; e_addr = i_d_addr; e_wdata = i_d_wdata; e_be = i_d_be;
    end else if (ig) begin
      e_addr = i_if_addr; e_be = '1;
    end
    check("d_gnt",     o_d_gnt,     dg);
    check("if_gnt",    o_if_gnt,    ig);
    check("mem_en",    o_mem_en,    dg | ig);
    check("mem_wen",   o_mem_wen,   e_wen);
    check("mem_addr",  o_mem_addr,  e_addr);
    check("mem_wdata", o_mem_wdata, e_wdata);
    check("mem_be",    o_mem_be,    e_be);
    check("if_rvalid", o_if_rvalid, m_pend == 1);
    check("if_rdata",  o_if_rdata,  (m_pend == 1) ? m_pend_data : '0);
    check("d_rvalid",  o_d_rvalid,  m_pend == 2);
    check("d_rdata",   o_d_rdata,   (m_pend == 2) ? m_pend_data : '0);
    cap_en = o_mem_en; cap_wen = o_mem_wen; cap_addr = o_mem_addr;
    cap_wdata = o_mem_wdata; cap_be = o_mem_be;
    idx = int'(e_addr[7:2]);
    m_pend = 0;
    if (ig) begin
      m_pend = 1; m_pend_data = ref_mem[idx];
    end else if (dg && !e_wen) begin
      m_pend = 2; m_pend_data = ref_mem[idx];
    end else if (dg) begin
      ref_mem[idx] = merge(ref_mem[idx], e_wdata, e_be);
    end
    if (i_if_req && !ig) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
    else                 m_wait = 0;
    m_ig = ig; m_dg = dg;
    if (!i_rstn) begin
      m_pend = 0; m_wait = 0;
    end
  endtask

  // Rising edge: the memory macro performs the captured access.
  task automatic clock_edge();
    int idx;
    @(posedge i_clk);
    idx = int'(cap_addr[7:2]);
    if (cap_en && !cap_wen) i_mem_rdata = env_mem[idx];
    else                    i_mem_rdata = $urandom;
    if (cap_en && cap_wen) env_mem[idx] = merge(env_mem[idx], cap_wdata, cap_be);
    #1;
  endtask

  task automatic cycle();
    eval_cycle();
    clock_edge();
  endtask

  task automatic set_if(input logic req, input logic [AW-1:0] addr);
    i_if_req = req; i_if_addr = addr;
  endtask

  task automatic set_d(input logic req, input logic wen, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [BW-1:0] be);
    i_d_req = req; i_d_wen = wen; i_d_addr = addr; i_d_wdata = wdata; i_d_be = be;
  endtask

  initial begin
    for (int i = 0; i < NWORDS; i++) begin
      env_mem[i] = '0; ref_mem[i] = '0;
    end
    env_mem[4] = 32'h0050_0093; ref_mem[4] = 32'h0050_0093;   // address 0x10
    m_pend = 0; m_pend_data = '0; m_wait = 0; m_ig = 0; m_dg = 0;
    cap_en = 0; cap_wen = 0; cap_addr = '0; cap_wdata = '0; cap_be = '0;
    i_mem_rdata = 32'hA5A5_A5A5;
    set_if(0, '0);
    set_d(0, 0, '0, '0, '0);

    // Reset with no requests: everything zero.
    i_rstn = 1'b0;
    cycle();
    cycle();
    i_rstn = 1'b1;
    cycle();

    // Fetch only: grant in N, instruction back in N+1.
    set_if(1, 32'h10);
    eval_cycle();
    check("fetch_gnt_n", o_if_gnt, 1);
    clock_edge();
    set_if(0, '0);
    eval_cycle();
    check("fetch_rvalid_n1", o_if_rvalid, 1);
    check("fetch_rdata_n1", o_if_rdata, 32'h0050_0093);
    clock_edge();

    // Store then load of 0x200 with partial byte enables.
    set_d(1, 1, 32'h200, 32'hDEAD_BEEF, 4'b0011);
    eval_cycle();
    check("st_mem_wen", o_mem_wen, 1);
    check("st_mem_be", o_mem_be, 4'b0011);
    clock_edge();
    set_d(0, 0, '0, '0, '0);
    eval_cycle();
    check("st_no_rvalid", o_d_rvalid, 0);
    clock_edge();
    set_d(1, 0, 32'h200, '0, '0);
    cycle();
    set_d(0, 0, '0, '0, '0);
    eval_cycle();
    check("ld_rdata", o_d_rdata, 32'h0000_BEEF);
    clock_edge();

    // Contention: both held high; data in 0..3, fetch in 4, data in 5.
    for (int c = 0; c < 7; c++) begin
      set_if(1, 32'h40);
      set_d(1, 0, 32'(($urandom_range(0, NWORDS - 1)) << 2), '0, '0);
      eval_cycle();
      check("cont_d_gnt", o_d_gnt, (c < 4) || (c == 5) || (c == 6));
      clock_edge();
      if (m_ig) set_if(0, '0);
    end
    set_if(0, '0);
    set_d(0, 0, '0, '0, '0);
    cycle();
    cycle();

    // Back-to-back alternating load/fetch, one cycle each.
    for (int c = 0; c < 8; c++) begin
      if (c[0]) begin set_if(1, 32'(c * 4)); set_d(0, 0, '0, '0, '0); end
      else      begin set_if(0, '0); set_d(1, 0, 32'(c * 8), '0, '0); end
      cycle();
    end
    set_if(0, '0);
    set_d(0, 0, '0, '0, '0);
    cycle();

    // Data drops in the cycle the counter would saturate: fetch wins, count clears.
    set_if(1, 32'h24);
    for (int c = 0; c < 3; c++) begin
      set_d(1, 0, 32'h8, '0, '0);
      cycle();
    end
    set_d(0, 0, '0, '0, '0);
    eval_cycle();
    check("drop_if_gnt", o_if_gnt, 1);
    clock_edge();
    set_if(1, 32'h28);
    set_d(1, 0, 32'hC, '0, '0);
    eval_cycle();
    check("drop_cnt_cleared_d_wins", o_d_gnt, 1);
    clock_edge();
    set_if(0, '0);
    set_d(0, 0, '0, '0, '0);
    for (int c = 0; c < 5; c++) cycle();

    // Reset asserted mid-cycle after a fetch grant: no rvalid follows.
    set_if(1, 32'h10);
    eval_cycle();
    #2 i_rstn = 1'b0;
    m_pend = 0; m_wait = 0;
    clock_edge();
    set_if(0, '0);
    eval_cycle();
    check("rst_drop_if_rvalid", o_if_rvalid, 0);
    i_rstn = 1'b1;
    clock_edge();
    cycle();

    // Reset while a response is being delivered: rvalid drops at once.
    set_if(1, 32'h10);
    cycle();
    set_if(0, '0);
    check("pre_rst_if_rvalid", o_if_rvalid, 1);
    i_rstn = 1'b0;
    #1;
    check("async_rst_if_rvalid", o_if_rvalid, 0);
    m_pend = 0; m_wait = 0;
    eval_cycle();
    #2 i_rstn = 1'b1;
    clock_edge();
    cycle();

    // Randomized traffic obeying the hold-until-granted contract.
    for (int c = 0; c < 1500; c++) begin
      if (!i_if_req || m_ig) begin
        if ($urandom_range(0, 3) != 0) set_if(1, 32'($urandom_range(0, NWORDS - 1) << 2));
        else                            set_if(0, '0);
      end
      if (!i_d_req || m_dg) begin
        if ($urandom_range(0, 3) != 0)
          set_d(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, NWORDS - 1) << 2),
                $urandom, 4'($urandom_range(0, 15)));
        else
          set_d(0, 0, '0, '0, '0);
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
